// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter with a byte FIFO.
// Registers at BASE_ADDR: TXDATA (+0), STATUS (+8), DIVISOR (+16).
module mmio_uart_tx #(
    parameter logic [63:0] BASE_ADDR       = 64'h0000_0000_0001_0000,
    parameter int          FIFO_DEPTH      = 8,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd434
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic [63:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [63:0] rdata,
    output logic        sel,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ovf_q, ovf_d;
    logic [15:0]   div_q, div_d;
    logic [7:0]    shreg_q, shreg_d;
    logic [15:0]   per_q, per_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic          tx_q, tx_d;
    logic          irq_q, irq_d;

    logic hit_tx, hit_st, hit_div;
    logic push, push_ok, pop;
    logic full, empty, busy, bit_end;
    logic [7:0] status;
    logic unused_wdata;

    assign hit_tx  = (address == BASE_ADDR);
    assign hit_st  = (address == BASE_ADDR + 64'd8);
    assign hit_div = (address == BASE_ADDR + 64'd16);
    assign sel     = hit_tx | hit_st | hit_div;

    assign full    = (cnt_q == CW'(FIFO_DEPTH));
    assign empty   = (cnt_q == '0);
    assign busy    = (state_q != IDLE);
    assign push    = wr_en & hit_tx;
    assign push_ok = push & ~full;
    assign bit_end = (baud_q == per_q - 16'd1);

    assign status = {4'(cnt_q), ovf_q, busy, empty, full};
    assign unused_wdata = ^wdata[63:16];

    always_comb begin
        rdata = '0;
        if (rd_en && hit_st) begin
            rdata = {56'd0, status};
        end else if (rd_en && hit_div) begin
            rdata = {48'd0, div_q};
        end
    end

    // A push into a full FIFO is lost even if a pop frees a slot this edge.
    always_comb begin
        ovf_d = ovf_q;
        if (push && full) begin
            ovf_d = 1'b1;
        end else if (rd_en && hit_st) begin
            ovf_d = 1'b0;
        end
    end

    always_comb begin
        div_d = div_q;
        if (wr_en && hit_div) begin
            div_d = wdata[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        per_d   = per_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                pop  = ~empty;
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    tx_d    = shreg_q[0];
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        bit_d   = bit_q + 3'd1;
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (!empty) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
        endcase
        // Frame start: load head byte and freeze the bit period.
        if (pop) begin
            state_d = START;
            shreg_d = mem_q[rptr_q];
            per_d   = (div_q == 16'd0) ? 16'd1 : div_q;
            baud_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b0;
        end
    end

    assign cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
    assign irq_d = (cnt_d == '0) && (state_d == IDLE);

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wptr_q] <= wdata[7:0];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            div_q   <= DEFAULT_DIVISOR;
            shreg_q <= '0;
            per_q   <= 16'd1;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            irq_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            if (push_ok) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            div_q   <= div_d;
            shreg_q <= shreg_d;
            per_q   <= per_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            irq_q   <= irq_d;
        end
    end

    assign tx  = tx_q;
    assign irq = irq_q;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: frame-timing reference model of the UART, compared
// every cycle, plus directed literal checks and a randomized phase.
module tb_mmio_uart_tx;
    localparam logic [63:0] B = 64'h0000_0000_0001_0000;

    logic        clock, reset;
    logic [63:0] address, wdata;
    logic        wr_en, rd_en;
    logic [63:0] rdata;
    logic        sel, tx, irq;

    int errors = 0;
    int checks = 0;

    mmio_uart_tx dut (
        .clock  (clock),
        .reset  (reset),
        .address(address),
        .wdata  (wdata),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .rdata  (rdata),
        .sel    (sel),
        .tx     (tx),
        .irq    (irq)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    // Model: FIFO as a queue; a frame is 10*P clocks indexed by t.
    logic [7:0]  mq[$];
    bit          m_active = 0;
    int          m_t = 0;
    int          m_p = 1;
    logic [7:0]  m_b = '0;
    logic [15:0] m_div = 16'd434;
    bit          m_ovf = 0;

    function automatic logic m_tx();
        if (!m_active) return 1'b1;
        if (m_t < m_p) return 1'b0;
        if (m_t < 9 * m_p) return m_b[(m_t - m_p) / m_p];
        return 1'b1;
    endfunction

    function automatic logic [63:0] m_rdata();
        logic [7:0] st;
        st = {4'(mq.size()), m_ovf, m_active, mq.size() == 0,
              mq.size() == 8};
        if (rd_en && address == B + 64'd8) return {56'd0, st};
        if (rd_en && address == B + 64'd16) return {48'd0, m_div};
        return 64'd0;
    endfunction

    initial begin
        forever begin
            int         pre;
            bit         do_pop, fend, dropped;
            logic [7:0] nb;
            logic       esel;
            @(negedge clock);
            if (!reset) begin
                mq.delete();
                m_active = 0;
                m_t = 0;
                m_p = 1;
                m_div = 16'd434;
                m_ovf = 0;
            end else begin
                pre = mq.size();
                fend = m_active && (m_t == 10 * m_p - 1);
                do_pop = (pre > 0) && (!m_active || fend);
                dropped = 0;
                nb = '0;
                if (do_pop) nb = mq.pop_front();
                if (wr_en && address == B) begin
                    if (pre == 8) dropped = 1;
                    else mq.push_back(wdata[7:0]);
                end
                if (dropped) m_ovf = 1;
                else if (rd_en && address == B + 64'd8) m_ovf = 0;
                if (do_pop) begin
                    m_b = nb;
                    m_p = (m_div == 0) ? 1 : int'(m_div);
                    m_t = 0;
                    m_active = 1;
                end else if (fend) begin
                    m_active = 0;
                end else if (m_active) begin
                    m_t++;
                end
                if (wr_en && address == B + 64'd16) m_div = wdata[15:0];
            end
            esel = (address == B) || (address == B + 64'd8) ||
                   (address == B + 64'd16);
            chk("tx", 64'(tx), 64'(m_tx()));
            chk("irq", 64'(irq), 64'(!m_active && mq.size() == 0));
            chk("sel", 64'(sel), 64'(esel));
            chk("rdata", rdata, m_rdata());
        end
    end

    task automatic cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        address = a;
        wdata = d;
        wr_en = 1'b1;
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic rd(input logic [63:0] a, input logic [63:0] exp,
                      input string name);
        address = a;
        rd_en = 1'b1;
        #1;
        chk(name, rdata, exp);
        cyc();
        rd_en = 1'b0;
    endtask

    // Counts sampled cycles with irq low; a frame of 10*P gives 10*P+1.
    task automatic len_chk(input string name, input int exp,
                           input int budget);
        int n = 0;
        while (irq === 1'b0 && n < budget) begin
            n++;
            cyc();
        end
        chk(name, 64'(n), 64'(exp));
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (irq !== 1'b1 && n < budget) begin
            n++;
            cyc();
        end
        chk("drain_irq", 64'(irq), 64'd1);
    endtask

    logic [63:0] addrs [8];

    initial begin
        reset = 1'b0;
        address = '0;
        wdata = '0;
        wr_en = 1'b0;
        rd_en = 1'b0;
        addrs[0] = B;
        addrs[1] = B + 64'd8;
        addrs[2] = B + 64'd16;
        addrs[3] = B + 64'd1;
        addrs[4] = B + 64'd4;
        addrs[5] = B + 64'd24;
        addrs[6] = B + 64'd32;
        addrs[7] = B - 64'd8;
        repeat (3) cyc();
        reset = 1'b1;
        cyc();

        chk("rst_tx", 64'(tx), 64'd1);
        chk("rst_irq", 64'(irq), 64'd1);
        rd(B + 64'd8, 64'h2, "rst_status");
        rd(B + 64'd16, 64'd434, "rst_div");

        wr(B + 64'd16, 64'd4);
        wr(B, 64'hA5);
        len_chk("frame_p4", 41, 200);

        wr(B + 64'd16, 64'd1);
        for (int i = 0; i < 9; i++) wr(B, 64'(8'h30 + i));
        rd(B + 64'd8, 64'h85, "b2b_status");
        drain(300);
        rd(B + 64'd8, 64'h2, "b2b_done");

        wr(B + 64'd16, 64'd0);
        wr(B, 64'h3C);
        len_chk("frame_p0", 11, 100);
        wr(B, 64'hC3);
        cyc();
        cyc();
        wr(B + 64'd16, 64'd8);
        len_chk("midframe_div", 8, 100);
        wr(B, 64'h5A);
        len_chk("frame_p8", 81, 300);

        wr(B + 64'd16, 64'd1000);
        for (int i = 0; i < 10; i++) wr(B, 64'(8'h10 + i));
        rd(B + 64'd8, 64'h8D, "ovf_status");
        rd(B + 64'd8, 64'h85, "ovf_cleared");
        repeat (1500) cyc();
        chk("mid_data_tx", 64'(tx), 64'd0);
        reset = 1'b0;
        #1;
        chk("async_rst_tx", 64'(tx), 64'd1);
        chk("async_rst_irq", 64'(irq), 64'd1);
        address = B + 64'd8;
        rd_en = 1'b1;
        #1;
        chk("async_rst_status", rdata, 64'h2);
        rd_en = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
        wr(B, 64'h96);
        len_chk("frame_p434", 4341, 5000);

        wr(B + 64'd16, 64'd2);
        for (int i = 0; i < 2000; i++) begin
            logic [63:0] a;
            a = addrs[$urandom_range(0, 7)];
            address = a;
            wdata = {$urandom, $urandom};
            if (a == B + 64'd16) wdata[15:0] = 16'($urandom_range(0, 3));
            wr_en = ($urandom_range(0, 9) < 4);
            rd_en = ($urandom_range(0, 9) < 3);
            cyc();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        drain(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
